// File: rtl/register_file_pkg.sv
// ============================================================================
// Module      : register_file_pkg
// Description : Shared pipeline signal types and defaults for the writeback
//               interface consumed by register_file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_file_pkg;

  localparam int NUM_REGS_DEFAULT = 32;
  localparam int XLEN_DEFAULT     = 32;

  // Writeback result source selects, used by the writeback stage mux.
  localparam logic [1:0] WBSRC_ALU = 2'd0;
  localparam logic [1:0] WBSRC_MEM = 2'd1;
  localparam logic [1:0] WBSRC_PC4 = 2'd2;

  typedef struct packed {
    logic                    RegWrite;
    logic [4:0]              rd;
    logic [XLEN_DEFAULT-1:0] Value;
  } WritebackSignals_t;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register in-flight write counters, RAW/WAW stall and
//               sticky underflow flag. Honours REGFILE_BYPASS_EN for busy().
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = 2
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_WbWrite,
  input  logic [4:0] i_WbRd,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_IssueValid,
  input  logic       i_IssueRegWrite,
  input  logic [4:0] i_IssueRd,
  input  logic       i_IssueUsesRs1,
  input  logic       i_IssueUsesRs2,
  input  logic       i_CancelValid,
  input  logic [4:0] i_CancelRd,
  output logic       o_Stall,
  output logic       o_ScoreboardError
);

  logic [PEND_W-1:0]   r_pend [NUM_REGS];
  logic [PEND_W-1:0]   w_next [NUM_REGS];
  logic [NUM_REGS-1:0] w_under;
  logic                r_err;
  logic                w_wbFire;
  logic                w_cancelFire;
  logic                w_issueFire;
  logic                w_busy1;
  logic                w_busy2;
  logic                w_wawFull;

  assign w_wbFire     = i_WbWrite && (i_WbRd != 5'd0);
  assign w_cancelFire = i_CancelValid && (i_CancelRd != 5'd0);
  assign w_issueFire  = i_IssueValid && i_IssueRegWrite && !o_Stall && (i_IssueRd != 5'd0);

`ifdef REGFILE_BYPASS_EN
  // A writeback landing this cycle already satisfies one reservation.
  assign w_busy1 = r_pend[i_rs1] != PEND_W'(w_wbFire && (i_WbRd == i_rs1));
  assign w_busy2 = r_pend[i_rs2] != PEND_W'(w_wbFire && (i_WbRd == i_rs2));
`else
  assign w_busy1 = r_pend[i_rs1] != '0;
  assign w_busy2 = r_pend[i_rs2] != '0;
`endif

  assign w_wawFull = r_pend[i_IssueRd] == '1;
  assign o_Stall   = (i_IssueUsesRs1 && w_busy1) || (i_IssueUsesRs2 && w_busy2) ||
                     (i_IssueRegWrite && w_wawFull);

  always_comb begin
    logic [PEND_W:0] sum;
    logic [PEND_W:0] dec;
    sum = '0;
    dec = '0;
    w_under = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_next[i] = '0;
      if (i != 0) begin
        sum = {1'b0, r_pend[i]} + (PEND_W+1)'(w_issueFire && (i_IssueRd == 5'(i)));
        dec = (PEND_W+1)'(w_wbFire && (i_WbRd == 5'(i))) +
              (PEND_W+1)'(w_cancelFire && (i_CancelRd == 5'(i)));
        if (sum < dec) begin
          w_under[i] = 1'b1;
        end else begin
          w_next[i] = PEND_W'(sum - dec);
        end
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
      r_err <= 1'b0;
    end else begin
      r_pend <= w_next;
      r_err  <= r_err | (|w_under);
    end
  end

  assign o_ScoreboardError = r_err;

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module      : register_file
// Description : Architectural register file with two combinational read ports
//               and hazard scoreboard. Macro REGFILE_BYPASS_EN enables
//               same-cycle writeback forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file
  import register_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int PEND_W   = 2
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  WritebackSignals_t i_WritebackSignals,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  output logic [XLEN-1:0]   o_rs1Value,
  output logic [XLEN-1:0]   o_rs2Value,
  input  logic              i_IssueValid,
  input  logic              i_IssueRegWrite,
  input  logic [4:0]        i_IssueRd,
  input  logic              i_IssueUsesRs1,
  input  logic              i_IssueUsesRs2,
  input  logic              i_CancelValid,
  input  logic [4:0]        i_CancelRd,
  output logic              o_Stall,
  output logic              o_ScoreboardError
);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            w_wbWrite;

  assign w_wbWrite = i_WritebackSignals.RegWrite && (i_WritebackSignals.rd != 5'd0);

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wbWrite) begin
      r_regs[i_WritebackSignals.rd] <= i_WritebackSignals.Value;
    end
  end

  always_comb begin
    o_rs1Value = (i_rs1 == 5'd0) ? '0 : r_regs[i_rs1];
    o_rs2Value = (i_rs2 == 5'd0) ? '0 : r_regs[i_rs2];
`ifdef REGFILE_BYPASS_EN
    if (w_wbWrite && (i_WritebackSignals.rd == i_rs1)) o_rs1Value = i_WritebackSignals.Value;
    if (w_wbWrite && (i_WritebackSignals.rd == i_rs2)) o_rs2Value = i_WritebackSignals.Value;
`endif
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .PEND_W   (PEND_W)
  ) u_scoreboard (
    .i_Clock           (i_Clock),
    .i_Reset_n         (i_Reset_n),
    .i_WbWrite         (i_WritebackSignals.RegWrite),
    .i_WbRd            (i_WritebackSignals.rd),
    .i_rs1             (i_rs1),
    .i_rs2             (i_rs2),
    .i_IssueValid      (i_IssueValid),
    .i_IssueRegWrite   (i_IssueRegWrite),
    .i_IssueRd         (i_IssueRd),
    .i_IssueUsesRs1    (i_IssueUsesRs1),
    .i_IssueUsesRs2    (i_IssueUsesRs2),
    .i_CancelValid     (i_CancelValid),
    .i_CancelRd        (i_CancelRd),
    .o_Stall           (o_Stall),
    .o_ScoreboardError (o_ScoreboardError)
  );

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;
  import register_file_pkg::*;

  logic              clk;
  logic              rstN;
  WritebackSignals_t wb;
  logic [4:0]        rs1, rs2;
  logic [31:0]       rs1Value, rs2Value;
  logic              issueValid, issueRegWrite, usesRs1, usesRs2, cancelValid;
  logic [4:0]        issueRd, cancelRd;
  logic              stall, sbErr;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .i_Clock            (clk),
    .i_Reset_n          (rstN),
    .i_WritebackSignals (wb),
    .i_rs1              (rs1),
    .i_rs2              (rs2),
    .o_rs1Value         (rs1Value),
    .o_rs2Value         (rs2Value),
    .i_IssueValid       (issueValid),
    .i_IssueRegWrite    (issueRegWrite),
    .i_IssueRd          (issueRd),
    .i_IssueUsesRs1     (usesRs1),
    .i_IssueUsesRs2     (usesRs2),
    .i_CancelValid      (cancelValid),
    .i_CancelRd         (cancelRd),
    .o_Stall            (stall),
    .o_ScoreboardError  (sbErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and leave time for outputs to settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb = '0; issueValid = 0; issueRegWrite = 0; issueRd = 0;
    usesRs1 = 0; usesRs2 = 0; cancelValid = 0; cancelRd = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issueValid = 1; issueRegWrite = 1; issueRd = rd;
  endtask

  initial begin
    idle();
    rs1 = 0; rs2 = 0; rstN = 0;
    tick(); tick();
    rstN = 1;
    #1;

    // Reset state
    rs1 = 5; rs2 = 5; usesRs1 = 1; usesRs2 = 1; #1;
    check("reset_rd_x5", rs1Value, 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_err", 32'(sbErr), 32'h0);

    // Reserve x5, then write it back
    idle(); issue(5); tick();
    idle(); wb = '{RegWrite: 1'b1, rd: 5'd5, Value: 32'hDEADBEEF}; #1;
`ifdef REGFILE_BYPASS_EN
    check("wb_cycle_rd_x5", rs1Value, 32'hDEADBEEF);
`else
    check("wb_cycle_rd_x5", rs1Value, 32'h0);
`endif
    tick(); idle(); #1;
    check("after_wb_rd_x5", rs1Value, 32'hDEADBEEF);
    check("after_wb_rd2_x5", rs2Value, 32'hDEADBEEF);

    // x0 write is discarded
    wb = '{RegWrite: 1'b1, rd: 5'd0, Value: 32'h1234}; tick(); idle();
    rs1 = 0; usesRs1 = 1; #1;
    check("x0_read", rs1Value, 32'h0);
    check("x0_not_busy", 32'(stall), 32'h0);
    check("x0_no_err", 32'(sbErr), 32'h0);

    // RAW on x7
    idle(); issue(7); tick();
    idle(); rs1 = 7; usesRs1 = 1; #1;
    check("raw_stall_1", 32'(stall), 32'h1);
    tick(); #0;
    check("raw_stall_2", 32'(stall), 32'h1);
    wb = '{RegWrite: 1'b1, rd: 5'd7, Value: 32'h00000077}; #1;
`ifdef REGFILE_BYPASS_EN
    check("raw_wb_cycle_stall", 32'(stall), 32'h0);
    check("raw_wb_cycle_fwd", rs1Value, 32'h77);
`else
    check("raw_wb_cycle_stall", 32'(stall), 32'h1);
    check("raw_wb_cycle_val", rs1Value, 32'h0);
`endif
    tick(); wb = '0; #1;
    check("raw_after_stall", 32'(stall), 32'h0);
    check("raw_after_val", rs1Value, 32'h77);

    // Issue, writeback and cancel of x3 in the same cycle with pend[3]=1
    idle(); issue(3); tick();
    idle(); issue(3); cancelValid = 1; cancelRd = 3;
    wb = '{RegWrite: 1'b1, rd: 5'd3, Value: 32'h33}; #1;
    check("simul_no_stall", 32'(stall), 32'h0);
    tick(); idle(); rs1 = 3; usesRs1 = 1; #1;
    check("simul_pend3_zero", 32'(stall), 32'h0);
    check("simul_no_err", 32'(sbErr), 32'h0);
    check("simul_x3_val", rs1Value, 32'h33);

    // WAW saturation on x9
    idle(); issue(9); tick(); tick(); tick();
    #1;
    check("sat_stall", 32'(stall), 32'h1);
    tick();
    check("sat_stall_held", 32'(stall), 32'h1);
    wb = '{RegWrite: 1'b1, rd: 5'd9, Value: 32'h99}; #1;
    check("sat_stall_wb_cycle", 32'(stall), 32'h1);
    tick(); wb = '0; issueValid = 0; #1;
    check("sat_released", 32'(stall), 32'h0);
    idle(); rs1 = 9; usesRs1 = 1; #1;
    check("sat_still_busy", 32'(stall), 32'h1);

    // Underflow sets the sticky flag; reset clears everything
    idle(); wb = '{RegWrite: 1'b1, rd: 5'd4, Value: 32'h44}; tick();
    idle(); #1;
    check("underflow_err", 32'(sbErr), 32'h1);
    tick();
    check("underflow_sticky", 32'(sbErr), 32'h1);
    rstN = 0; tick(); rstN = 1; #1;
    check("reset_err_clear", 32'(sbErr), 32'h0);
    rs1 = 5; rs2 = 7; #1;
    check("reset_x5_zero", rs1Value, 32'h0);
    check("reset_x7_zero", rs2Value, 32'h0);
    rs1 = 9; usesRs1 = 1; issueRegWrite = 1; issueRd = 9; #1;
    check("reset_x9_free", 32'(stall), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file.md
# register_file

Architectural integer register file plus in-flight hazard scoreboard, the consumer end of the writeback interface. It commits the `WritebackSignals_t` bundle driven by the writeback stage. It serves two combinational read ports to decode. It tracks outstanding destination writes so that decode stalls on RAW and WAW hazards instead of reading stale operands.

## Interface
Parameters:
- `NUM_REGS`, 32: architectural registers. x0 reads as zero and is never written.
- `XLEN`, 32: data width.
- `PEND_W`, 2: width of each per-register pending counter. At most 2^PEND_W−1 in-flight writes per register.

Ports:
- `i_Clock` in 1: sole clock, rising edge.
- `i_Reset_n` in 1: reset. Synchronous, active-low.
- `i_WritebackSignals` in `WritebackSignals_t`: `.RegWrite`, `.rd[4:0]`, `.Value[XLEN-1:0]`.
- `i_rs1`, `i_rs2` in 5 each: read addresses from decode.
- `o_rs1Value`, `o_rs2Value` out XLEN each: read data, combinational.
- `i_IssueValid` in 1: decode issues an instruction this cycle. Only honoured when `o_Stall`=0.
- `i_IssueRegWrite` in 1: the issued instruction writes `i_IssueRd`.
- `i_IssueRd` in 5: destination of the issued instruction.
- `i_IssueUsesRs1`, `i_IssueUsesRs2` in 1 each: operand-use qualifiers for the hazard check.
- `i_CancelValid` in 1, `i_CancelRd` in 5: a squashed in-flight instruction releases its reservation.
- `o_Stall` out 1: decode must hold. Combinational.
- `o_ScoreboardError` out 1: sticky underflow flag.

## Operation
- **Write:** at the rising edge, if `RegWrite`=1 and `rd`≠0, set `regs[rd] <= Value`. Writes to x0 are discarded.
- **Read:** `o_rsNValue = (rsN==0) ? 0 : regs[rsN]`, subject to the bypass rules under Configuration.
- **Scoreboard:** one `PEND_W`-bit counter `pend[r]` per register. `pend[0]` is constant 0.
  - Increment: `i_IssueValid & i_IssueRegWrite & ~o_Stall & IssueRd≠0`.
  - Decrement: writeback with `RegWrite` and `rd≠0`.
  - Decrement: `i_CancelValid & CancelRd≠0`.
  - All three may hit the same register in the same cycle. The net delta is in {−2..+1}, applied in one update.
  - Decrementing below zero saturates at 0 and sets `o_ScoreboardError`. The flag stays set until reset.
- **Stall:** `o_Stall` asserts if either condition holds:
  - RAW: `(UsesRs1 & busy(rs1)) | (UsesRs2 & busy(rs2))`.
  - WAW overflow: `IssueRegWrite & pend[IssueRd]==2^PEND_W−1`.
  - `busy(r)` is defined under Configuration.
  - `o_Stall` is a function of the current-cycle inputs only. It does not depend on `i_IssueValid`.
- **Reset** (`i_Reset_n`=0 at an edge):
  - All `regs` clear to 0, all `pend` clear to 0, `o_ScoreboardError` clears to 0.
  - Writeback, issue and cancel in that cycle are ignored.
  - Reset asserted mid-operation discards all reservations. The pipeline is reset simultaneously.

## Timing
- Write latency is 1 edge. Read and stall outputs are combinational from the addresses and `pend`.
- A reservation made at edge N is visible in `o_Stall` from cycle N+1.
- After reset, `o_Stall` is 0 for any operands and `o_rsNValue` is 0.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read with `rsN == i_WritebackSignals.rd`, `RegWrite`=1 and `rd`≠0 returns `i_WritebackSignals.Value` in the same cycle.
  - `busy(r) = pend[r] − (WB writes r this cycle) ≠ 0`, so decode proceeds in the writeback cycle.
- `REGFILE_BYPASS_EN` undefined:
  - Reads return the stored value only.
  - `busy(r) = pend[r] ≠ 0`. A dependent instruction stalls one extra cycle, until the edge after writeback.

## Structure
- The `WritebackSignals_t` typedef, the `WBSRC_*` constants and the `NUM_REGS`/`XLEN` defaults stay in the shared pipeline signals header/package. No new typedefs are local to this block.
- The natural sub-module is `regfile_scoreboard`: the counters, the delta logic, `busy`, the WAW check and the error flag. The top level holds the storage array and the read muxes.

## Test plan
- **Reset and write:** after reset, read x5 → 0. Writeback `{1, 5, 0xDEADBEEF}`. Next cycle x5 → 0xDEADBEEF.
- **x0 write:** writeback `{1, 0, 0x1234}` → x0 reads 0 and `pend[0]` stays 0.
- **RAW hazard:** issue rd=7, then a reader of rs1=7.
  - `o_Stall` is 1 until writeback of x7.
  - With bypass: stall drops in the writeback cycle and the value is forwarded.
  - Without bypass: stall drops 1 cycle later.
- **Simultaneous events:** with `pend[3]`=1, issue rd=3, writeback rd=3 and cancel rd=3 in the same cycle → `pend[3]`=0 next cycle.
- **Saturation:** issue rd=9 three times with `PEND_W`=2 → a fourth issue to rd=9 holds `o_Stall`=1. Writeback of 9 releases it.
- **Underflow and reset:** writeback rd=4 with `pend[4]`=0 → `o_ScoreboardError`=1 and stays set. Reset low for 1 edge → it clears and all registers read 0.
